// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor computing a - b - bin, LSB first, one bit per clock.
//   A single full-subtractor cell feeds a registered borrow. The result is held until the
//   next accepted start.
//
//   Optional build macro: SERIAL_SUB_OVF_EN adds the registered signed-overflow flag 'ovf'.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   request pulse, accepted only in IDLE
//   a, b       in   WIDTH-bit minuend / subtrahend, sampled on the accepting edge
//   bin        in   borrow-in, sampled on the accepting edge
//   busy       out  high while the bit loop runs
//   done       out  one-cycle pulse when diff/borrow_out are updated
//   diff       out  WIDTH-bit registered result
//   borrow_out out  registered final borrow
//   ovf        out  (SERIAL_SUB_OVF_EN only) signed overflow, held with diff

module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CntW-1:0]  r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_ovf;
`endif

    logic             w_a0;
    logic             w_b0;
    logic             w_d;
    logic             w_br_next;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        w_a0      = r_a_sh[0];
        w_b0      = r_b_sh[0];
        w_d       = w_a0 ^ w_b0 ^ r_br;
        w_br_next = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
        w_last    = (r_cnt == CntW'(WIDTH - 1));
    end

    // Result register with the new bit shifted in at the MSB; after WIDTH steps bit 0
    // holds the first (LSB) difference bit.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_next = w_d;
        end else begin : g_res_wn
            assign w_res_next = {w_d, r_res[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_br   <= w_br_next;
                    r_res  <= w_res_next;
                    r_cnt  <= r_cnt + CntW'(1);
                    if (w_last) begin
                        r_diff  <= w_res_next;
                        r_bout  <= w_br_next;
`ifdef SERIAL_SUB_OVF_EN
                        // Borrow into the MSB xor borrow out of the MSB.
                        r_ovf   <= r_br ^ w_br_next;
`endif
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_bout;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf        = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor: one WIDTH=8 and one WIDTH=1 instance
// sharing clock and reset. Inputs are driven and outputs sampled on the falling edge.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8;
    logic [7:0] a8, b8;
    logic       bin8;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    logic       start1;
    logic [0:0] a1, b1;
    logic       bin1;
    logic       busy1, done1, bout1;
    logic [0:0] diff1;

`ifdef SERIAL_SUB_OVF_EN
    logic       ovf8, ovf1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] held_diff8 = 8'h00;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .bin        (bin8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (bout8)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf8)
`endif
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .a          (a1),
        .b          (b1),
        .bin        (bin1),
        .busy       (busy1),
        .done       (done1),
        .diff       (diff1),
        .borrow_out (bout1)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One WIDTH=8 operation: expect 8 busy cycles, then a single done cycle with the result.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                        input logic [7:0] ediff, input logic ebout);
        int busy_cnt = 0;
        int waited   = 0;
        @(negedge clk);
        a8 = ta; b8 = tb_v; bin8 = tbin; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~ta; b8 = ~tb_v; bin8 = ~tbin;
        while (!done8 && waited < 40) begin
            if (busy8) busy_cnt++;
            waited++;
            @(negedge clk);
        end
        check("done8_seen", {31'd0, done8}, 32'd1);
        check("busy8_cycles", busy_cnt, 32'd8);
        check("busy8_with_done", {31'd0, busy8}, 32'd0);
        check("diff8", {24'd0, diff8}, {24'd0, ediff});
        check("bout8", {31'd0, bout8}, {31'd0, ebout});
        @(negedge clk);
        check("done8_one_cycle", {31'd0, done8}, 32'd0);
        check("diff8_held", {24'd0, diff8}, {24'd0, ediff});
        held_diff8 = ediff;
    endtask

    task automatic run1(input logic ta, input logic tb_v, input logic tbin);
        int  v;
        logic ed, eb;
        v  = int'(ta) - int'(tb_v) - int'(tbin);
        ed = v[0];
        eb = (v < 0);
        @(negedge clk);
        a1 = ta; b1 = tb_v; bin1 = tbin; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("w1_busy", {31'd0, busy1}, 32'd1);
        check("w1_early_done", {31'd0, done1}, 32'd0);
        @(negedge clk);
        check("w1_done", {31'd0, done1}, 32'd1);
        check("w1_diff", {31'd0, diff1}, {31'd0, ed});
        check("w1_bout", {31'd0, bout1}, {31'd0, eb});
        @(negedge clk);
    endtask

    initial begin
        int dones;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy8", {31'd0, busy8}, 32'd0);
        check("rst_done8", {31'd0, done8}, 32'd0);
        check("rst_diff8", {24'd0, diff8}, 32'd0);
        check("rst_bout8", {31'd0, bout8}, 32'd0);
        check("rst_busy1", {31'd0, busy1}, 32'd0);
        rst = 1'b0;

        // Basic and borrow cases.
        run8(8'h35, 8'h12, 1'b0, 8'h23, 1'b0);
        run8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        run8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);
        run8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        run8(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);

        // Signed overflow cases.
        run8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf_set", {31'd0, ovf8}, 32'd1);
`endif
        run8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf_clr", {31'd0, ovf8}, 32'd0);
`endif

        // start during RUN is ignored; diff must hold its old value until done.
        @(negedge clk);
        a8 = 8'h35; b8 = 8'h12; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        check("hold_in_run", {24'd0, diff8}, {24'd0, held_diff8});
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done8) dones++;
            if (done8) check("ignored_start_diff", {24'd0, diff8}, 32'h23);
            @(negedge clk);
        end
        check("ignored_start_dones", dones, 32'd1);
        check("ignored_start_idle", {31'd0, busy8}, 32'd0);

        // Reset mid-RUN abandons the operation. Previous diff (0x23) must clear.
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {31'd0, busy8}, 32'd0);
        check("midrst_done", {31'd0, done8}, 32'd0);
        check("midrst_diff", {24'd0, diff8}, 32'd0);
        check("midrst_bout", {31'd0, bout8}, 32'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) dones++;
            @(negedge clk);
        end
        check("midrst_no_activity", dones, 32'd0);
        held_diff8 = 8'h00;
        run8(8'h35, 8'h12, 1'b0, 8'h23, 1'b0);

        // WIDTH=1: full-subtractor truth table.
        for (int k = 0; k < 8; k++) begin
            logic [2:0] kv;
            kv = 3'(k);
            run1(kv[2], kv[1], kv[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
